// File: rtl/ldm_stm_sequencer.sv
// LDM/STM block-transfer sequencer: walks REG_LIST low-to-high against an ascending word block.
// Define LDM_STM_WB_EN to honour W (base writeback); otherwise W is ignored and the base is never updated.
module ldm_stm_sequencer #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic              L,
    input  logic              U,
    input  logic              P,
    input  logic              W,
    input  logic [3:0]        BASE_REG,
    input  logic [DATA_W-1:0] BASE_VAL,
    input  logic [15:0]       REG_LIST,
    output logic [3:0]        RF_A1,
    input  logic [DATA_W-1:0] RF_RD1,
    output logic [3:0]        RF_A3,
    output logic [DATA_W-1:0] RF_WD3,
    output logic              RF_WE3,
    output logic              PC_WE,
    output logic [DATA_W-1:0] PC_WD,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic              MEM_RE,
    output logic              MEM_WE,
    output logic [DATA_W-1:0] MEM_WDATA,
    input  logic [DATA_W-1:0] MEM_RDATA,
    input  logic              MEM_READY,
    output logic              BUSY,
    output logic              DONE
);

    typedef enum logic [2:0] {IDLE, SETUP, XFER, WB, FIN} state_t;

    localparam logic [ADDR_W-1:0] WORD = ADDR_W'(4);

    state_t             state, state_nxt;
    logic               l_q, u_q, p_q, w_q;
    logic [3:0]         base_reg_q;
    logic [ADDR_W-1:0]  base_q;
    logic [15:0]        list_q, rem_q;
    logic [ADDR_W-1:0]  addr_q, wbval_q;

    logic [4:0]         cnt;
    logic [ADDR_W-1:0]  span, start_addr, wbval;
    logic [3:0]         idx;
    logic               last;
    logic               wb_act;

    // Block geometry: the transfer always covers 4*N bytes in ascending order.
    always_comb begin
        cnt = '0;
        for (int i = 0; i < 16; i++) cnt = cnt + 5'(list_q[i]);
        span = ADDR_W'({cnt, 2'b00});
        case ({u_q, p_q})
            2'b10:   start_addr = base_q;
            2'b11:   start_addr = base_q + WORD;
            2'b00:   start_addr = base_q - span + WORD;
            default: start_addr = base_q - span;
        endcase
        wbval = u_q ? base_q + span : base_q - span;
    end

    always_comb begin
        idx = '0;
        for (int i = 15; i >= 0; i--) if (rem_q[i]) idx = 4'(i);
        last = (rem_q & (rem_q - 16'd1)) == '0;
    end

`ifdef LDM_STM_WB_EN
    // A base register that is also loaded keeps the loaded value.
    assign wb_act = w_q && !(l_q && list_q[base_reg_q]);
`else
    logic unused_w;
    assign unused_w = w_q;
    assign wb_act   = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            l_q        <= 1'b0;
            u_q        <= 1'b0;
            p_q        <= 1'b0;
            w_q        <= 1'b0;
            base_reg_q <= '0;
            base_q     <= '0;
            list_q     <= '0;
            rem_q      <= '0;
            addr_q     <= '0;
            wbval_q    <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (START) begin
                    l_q        <= L;
                    u_q        <= U;
                    p_q        <= P;
                    w_q        <= W;
                    base_reg_q <= BASE_REG;
                    base_q     <= ADDR_W'(BASE_VAL);
                    list_q     <= REG_LIST;
                    rem_q      <= REG_LIST;
                end
                SETUP: begin
                    addr_q  <= start_addr;
                    wbval_q <= wbval;
                end
                XFER: if (MEM_READY) begin
                    rem_q  <= rem_q & (rem_q - 16'd1);
                    addr_q <= addr_q + WORD;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        RF_A1     = '0;
        RF_A3     = '0;
        RF_WD3    = '0;
        RF_WE3    = 1'b0;
        PC_WE     = 1'b0;
        PC_WD     = '0;
        MEM_ADDR  = '0;
        MEM_RE    = 1'b0;
        MEM_WE    = 1'b0;
        MEM_WDATA = '0;
        BUSY      = state != IDLE;
        DONE      = 1'b0;
        case (state)
            IDLE:  if (START) state_nxt = SETUP;
            SETUP: state_nxt = (cnt == '0) ? FIN : XFER;
            XFER: begin
                MEM_ADDR = addr_q;
                MEM_RE   = l_q;
                MEM_WE   = !l_q;
                if (!l_q) begin
                    RF_A1     = idx;
                    MEM_WDATA = RF_RD1;
                end else if (idx != 4'd15) begin
                    RF_A3  = idx;
                    RF_WD3 = MEM_RDATA;
                    RF_WE3 = MEM_READY;
                end else begin
                    PC_WD = MEM_RDATA;
                    PC_WE = MEM_READY;
                end
                if (MEM_READY && last) state_nxt = wb_act ? WB : FIN;
            end
            WB: begin
                if (base_reg_q == 4'd15) begin
                    PC_WE = 1'b1;
                    PC_WD = DATA_W'(wbval_q);
                end else begin
                    RF_WE3 = 1'b1;
                    RF_A3  = base_reg_q;
                    RF_WD3 = DATA_W'(wbval_q);
                end
                state_nxt = FIN;
            end
            FIN: begin
                DONE      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Bench for ldm_stm_sequencer: directed scenarios plus randomized transfers against a list-level reference model.
module tb_ldm_stm_sequencer;

`ifdef LDM_STM_WB_EN
    localparam bit WB_EN = 1'b1;
`else
    localparam bit WB_EN = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RST, START, L, U, P, W;
    logic [3:0]  BASE_REG;
    logic [31:0] BASE_VAL;
    logic [15:0] REG_LIST;
    logic [3:0]  RF_A1, RF_A3;
    logic [31:0] RF_RD1, RF_WD3, PC_WD, MEM_ADDR, MEM_WDATA, MEM_RDATA;
    logic        RF_WE3, PC_WE, MEM_RE, MEM_WE, MEM_READY, BUSY, DONE;

    logic [31:0] rf  [16];
    logic [31:0] mem [256];

    always #5 CLK = ~CLK;

    assign RF_RD1    = rf[RF_A1];
    assign MEM_RDATA = mem[MEM_ADDR[9:2]];

    ldm_stm_sequencer #(.ADDR_W(32), .DATA_W(32)) dut (
        .CLK(CLK), .RST(RST), .START(START), .L(L), .U(U), .P(P), .W(W),
        .BASE_REG(BASE_REG), .BASE_VAL(BASE_VAL), .REG_LIST(REG_LIST),
        .RF_A1(RF_A1), .RF_RD1(RF_RD1), .RF_A3(RF_A3), .RF_WD3(RF_WD3), .RF_WE3(RF_WE3),
        .PC_WE(PC_WE), .PC_WD(PC_WD), .MEM_ADDR(MEM_ADDR), .MEM_RE(MEM_RE), .MEM_WE(MEM_WE),
        .MEM_WDATA(MEM_WDATA), .MEM_RDATA(MEM_RDATA), .MEM_READY(MEM_READY),
        .BUSY(BUSY), .DONE(DONE)
    );

    int tests = 0;
    int fails = 0;

    logic [63:0] exp_mw[$], obs_mw[$], exp_rd[$], obs_rd[$];
    logic [63:0] exp_rf[$], obs_rf[$], exp_pc[$], obs_pc[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cmp_q(input string tag, input logic [63:0] o[$], input logic [63:0] e[$]);
        check({tag, " count"}, 64'(o.size()), 64'(e.size()));
        for (int k = 0; k < o.size() && k < e.size(); k++)
            check($sformatf("%s #%0d", tag, k), o[k], e[k]);
    endtask

    function automatic logic any_out();
        return |{RF_A1, RF_A3, RF_WD3, RF_WE3, PC_WE, PC_WD, MEM_ADDR, MEM_RE, MEM_WE,
                 MEM_WDATA, BUSY, DONE};
    endfunction

    task automatic run_op(input bit l, input bit u, input bit p, input bit w,
                          input logic [3:0] br, input logic [31:0] bv, input logic [15:0] lst,
                          input int stall_pct, input int stall_k, input int stall_len,
                          input string tag);
        int regs[$];
        int n, cyc, done_cyc, busy_cnt, stalls, acc, stalled_k;
        logic [31:0] lo, wbv, a;
        logic [31:0] rf_s [16];
        logic [31:0] mem_s [256];
        bit wb, pend, rdy;
        logic [31:0] pend_addr, pend_wd;

        rf[br] = bv;
        rf_s  = rf;
        mem_s = mem;
        for (int i = 0; i < 16; i++) if (lst[i]) regs.push_back(i);
        n = regs.size();
        // Ascending block of n words; where it starts depends on direction and before/after
        if (u) lo = p ? bv + 32'd4 : bv;
        else   lo = p ? bv - 32'(4 * n) : bv - 32'(4 * n) + 32'd4;
        wbv = u ? bv + 32'(4 * n) : bv - 32'(4 * n);
        wb  = WB_EN && w && !(l && lst[br]) && n != 0;

        exp_mw = {}; obs_mw = {}; exp_rd = {}; obs_rd = {};
        exp_rf = {}; obs_rf = {}; exp_pc = {}; obs_pc = {};
        for (int k = 0; k < n; k++) begin
            a = lo + 32'(4 * k);
            if (!l) exp_mw.push_back({a, rf_s[regs[k]]});
            else begin
                exp_rd.push_back({32'h0, a});
                if (regs[k] == 15) exp_pc.push_back({32'h0, mem_s[a[9:2]]});
                else exp_rf.push_back({28'h0, 4'(regs[k]), mem_s[a[9:2]]});
            end
        end
        if (wb) begin
            if (br == 4'd15) exp_pc.push_back({32'h0, wbv});
            else exp_rf.push_back({28'h0, br, wbv});
        end

        @(negedge CLK);
        START = 1'b1; L = l; U = u; P = p; W = w;
        BASE_REG = br; BASE_VAL = bv; REG_LIST = lst; MEM_READY = 1'b1;
        #1;
        check({tag, " idle_at_start"}, 64'(BUSY), 64'd0);

        done_cyc = -1; busy_cnt = 0; stalls = 0; acc = 0; stalled_k = 0; pend = 1'b0;
        pend_addr = '0; pend_wd = '0;
        for (cyc = 1; cyc <= 400 && done_cyc < 0; cyc++) begin
            @(negedge CLK);
            // Scramble request inputs mid-operation: they must have been latched at START
            START    = ($urandom_range(3) == 0);
            L        = 1'($urandom); U = 1'($urandom); P = 1'($urandom); W = 1'($urandom);
            BASE_REG = 4'($urandom); BASE_VAL = $urandom; REG_LIST = 16'($urandom);
            rdy = (int'($urandom_range(99)) >= stall_pct);
            if (acc == stall_k && stalled_k < stall_len) rdy = 1'b0;
            MEM_READY = rdy;
            #1;
            if (BUSY) busy_cnt++;
            if (MEM_RE || MEM_WE) begin
                if (pend) check({tag, " held_request"}, {MEM_ADDR, MEM_WDATA}, {pend_addr, pend_wd});
                if (MEM_READY) begin
                    acc++;
                    pend = 1'b0;
                    if (MEM_WE) begin
                        obs_mw.push_back({MEM_ADDR, MEM_WDATA});
                        mem[MEM_ADDR[9:2]] = MEM_WDATA;
                    end
                    if (MEM_RE) obs_rd.push_back({32'h0, MEM_ADDR});
                end else begin
                    stalls++;
                    if (acc == stall_k) stalled_k++;
                    pend = 1'b1; pend_addr = MEM_ADDR; pend_wd = MEM_WDATA;
                end
            end
            if (RF_WE3) begin
                obs_rf.push_back({28'h0, RF_A3, RF_WD3});
                rf[RF_A3] = RF_WD3;
            end
            if (PC_WE) obs_pc.push_back({32'h0, PC_WD});
            if (DONE) done_cyc = cyc;
        end
        START = 1'b0;

        @(negedge CLK);
        MEM_READY = 1'b1;
        #1;
        check({tag, " done_seen"}, 64'(done_cyc >= 0), 64'd1);
        check({tag, " done_cycle"}, 64'(done_cyc), 64'(2 + n + stalls + int'(wb)));
        check({tag, " busy_cycles"}, 64'(busy_cnt), 64'(done_cyc));
        check({tag, " idle_after"}, 64'({BUSY, DONE}), 64'd0);
        if (stall_k >= 0) check({tag, " directed_stalls"}, 64'(stalled_k), 64'(stall_len));
        cmp_q({tag, " mem_write"}, obs_mw, exp_mw);
        cmp_q({tag, " mem_read"}, obs_rd, exp_rd);
        cmp_q({tag, " rf_write"}, obs_rf, exp_rf);
        cmp_q({tag, " pc_write"}, obs_pc, exp_pc);
    endtask

    initial begin
        int strobes;
        logic [15:0] lst;

        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        for (int i = 0; i < 16; i++) rf[i] = $urandom;
        RST = 1'b1; START = 1'b0; L = 1'b0; U = 1'b0; P = 1'b0; W = 1'b0;
        BASE_REG = '0; BASE_VAL = '0; REG_LIST = '0; MEM_READY = 1'b0;
        repeat (2) @(negedge CLK);
        #1;
        check("reset_outputs", 64'(any_out()), 64'd0);
        @(negedge CLK);
        RST = 1'b0;

        // STM IA with writeback
        rf[1] = 32'h11; rf[2] = 32'h22;
        run_op(1'b0, 1'b1, 1'b0, 1'b1, 4'd13, 32'h100, 16'h0006, 0, -1, 0, "stm_ia_wb");

        // LDM DB including R15
        mem[32'h1F8 >> 2] = 32'hAA; mem[32'h1FC >> 2] = 32'hBB;
        run_op(1'b1, 1'b0, 1'b1, 1'b0, 4'd6, 32'h200, 16'h8001, 0, -1, 0, "ldm_db_pc");

        // LDM IA where the base is loaded
        mem[32'h40 >> 2] = 32'h77;
        run_op(1'b1, 1'b1, 1'b0, 1'b1, 4'd3, 32'h40, 16'h0008, 0, -1, 0, "ldm_base_in_list");

        // STM IB with a 3-cycle stall on the second transfer
        rf[4] = 32'h4444; rf[5] = 32'h5555;
        run_op(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 32'h10, 16'h0030, 0, 1, 3, "stm_ib_stall");

        // Empty list
        run_op(1'b0, 1'b1, 1'b0, 1'b1, 4'd2, 32'h300, 16'h0000, 0, -1, 0, "empty_list");

        // Reset during the second transfer of a 4-register LDM
        @(negedge CLK);
        START = 1'b1; L = 1'b1; U = 1'b1; P = 1'b0; W = 1'b1;
        BASE_REG = 4'd1; BASE_VAL = 32'h80; REG_LIST = 16'h00F0; MEM_READY = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b1;
        #1;
        check("rst_mid_xfer_active", 64'({BUSY, MEM_RE}), 64'd3);
        @(negedge CLK);
        RST = 1'b0;
        #1;
        check("rst_mid_outputs", 64'(any_out()), 64'd0);
        strobes = 0;
        repeat (6) begin
            @(negedge CLK);
            #1;
            if (RF_WE3 || PC_WE || MEM_RE || MEM_WE || BUSY) strobes++;
        end
        check("rst_mid_no_strobes", 64'(strobes), 64'd0);
        run_op(1'b1, 1'b0, 1'b0, 1'b1, 4'd9, 32'h280, 16'h0A05, 0, -1, 0, "restart_after_rst");

        // Randomized transfers with random backpressure
        for (int t = 0; t < 40; t++) begin
            case ($urandom_range(3))
                0:       lst = 16'h1 << $urandom_range(15);
                1:       lst = 16'hFFFF;
                default: lst = 16'($urandom);
            endcase
            if ($urandom_range(7) == 0) lst = 16'h0000;
            run_op(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 4'($urandom),
                   $urandom & 32'hFFFF_FFFC, lst, 25, -1, 0, $sformatf("rand%0d", t));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
